// File: rtl/input_block_former_pkg.sv
// Shared pixel/block geometry for the raster-to-2x8-block former, plus packing helpers.
package input_block_former_pkg;

  localparam int unsigned PixW      = 14;
  localparam int unsigned NumComp   = 3;
  localparam int unsigned GroupSize = 4;
  localparam int unsigned BlkRows   = 2;
  localparam int unsigned BlkCols   = 8;
  localparam int unsigned BlkPix    = BlkRows * BlkCols;
  localparam int unsigned GrpW      = GroupSize * NumComp * PixW;
  localparam int unsigned BlkW      = BlkPix * NumComp * PixW;

  // Groups are pixel-major {p3c2..p0c0}; blocks are component-major (cp, row, col).
  function automatic logic [BlkW-1:0] pack_block(input logic [GrpW-1:0] r0_lo,
                                                 input logic [GrpW-1:0] r0_hi,
                                                 input logic [GrpW-1:0] r1_lo,
                                                 input logic [GrpW-1:0] r1_hi);
    logic [BlkW-1:0] b;
    b = '0;
    for (int cp = 0; cp < NumComp; cp++) begin
      for (int p = 0; p < GroupSize; p++) begin
        b[(cp*BlkPix + p)*PixW +: PixW]                     = r0_lo[(p*NumComp + cp)*PixW +: PixW];
        b[(cp*BlkPix + GroupSize + p)*PixW +: PixW]         = r0_hi[(p*NumComp + cp)*PixW +: PixW];
        b[(cp*BlkPix + BlkCols + p)*PixW +: PixW]           = r1_lo[(p*NumComp + cp)*PixW +: PixW];
        b[(cp*BlkPix + BlkCols + GroupSize + p)*PixW +: PixW] =
            r1_hi[(p*NumComp + cp)*PixW +: PixW];
      end
    end
    return b;
  endfunction

  // Right-edge padding: every pixel takes the value of the group's last pixel.
  function automatic logic [GrpW-1:0] rep_last(input logic [GrpW-1:0] g);
    logic [GrpW-1:0] r;
    r = '0;
    for (int p = 0; p < GroupSize; p++) begin
      for (int c = 0; c < NumComp; c++) begin
        r[(p*NumComp + c)*PixW +: PixW] = g[((GroupSize-1)*NumComp + c)*PixW +: PixW];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/input_block_former_dp_ram.sv
// Simple dual-port line buffer: one write port, one registered read port.
module input_block_former_dp_ram #(
  parameter int unsigned Depth = 640,
  parameter int unsigned Width = 168,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/input_block_former.sv
// Collects 4-pixel raster groups over two rows and emits 2x8 blocks through one output register.
module input_block_former
  import input_block_former_pkg::*;
#(
  parameter int unsigned MAX_SLICE_WIDTH = 2560
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [$clog2(MAX_SLICE_WIDTH)-1:0] slice_width,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_sof,
  input  logic [GrpW-1:0]                    in_data_p,
  output logic                               blk_valid,
  input  logic                               blk_ready,
  output logic                               blk_sof,
  output logic [BlkW-1:0]                    blk_p
);

  localparam int unsigned SwW   = $clog2(MAX_SLICE_WIDTH);
  localparam int unsigned GW    = SwW - 2;
  localparam int unsigned Depth = MAX_SLICE_WIDTH / GroupSize;

  logic [GW-1:0]   g_q, g_d, last_g, rd_addr, wr_addr;
  logic            odd_q, odd_d;
  logic [SwW-1:0]  width_q, width_d;
  logic            stg_vld_q, stg_vld_d, sof_pend_q, sof_pend_d;
  logic [GrpW-1:0] stg_e_q, stg_e_d, stg_o_q, stg_o_d, rd_data;
  logic            blk_valid_q, blk_valid_d, blk_sof_q, blk_sof_d;
  logic [BlkW-1:0] blk_p_q, blk_p_d;
  logic            accept, last_grp, cmpl_pos, complete, wr_en;

  assign last_g   = width_q[SwW-1:2] - GW'(1);
  assign last_grp = (g_q == last_g);
  // Odd g closes a staged pair; an even last g closes a padded block on its own.
  assign cmpl_pos = odd_q & ((g_q[0] & stg_vld_q) | (~g_q[0] & last_grp));
  assign in_ready = ~(cmpl_pos & blk_valid_q & ~blk_ready);
  assign accept   = in_valid & in_ready;
  assign complete = accept & ~in_sof & cmpl_pos;
  assign wr_en    = accept & (in_sof | ~odd_q);
  assign wr_addr  = in_sof ? '0 : g_q;
  // Read the next expected column now so the even partner is ready when it arrives.
  assign rd_addr  = g_d;

  input_block_former_dp_ram #(
    .Depth (Depth),
    .Width (GrpW)
  ) u_dp_ram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (in_data_p),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_comb begin
    g_d        = g_q;
    odd_d      = odd_q;
    width_d    = width_q;
    stg_vld_d  = stg_vld_q;
    sof_pend_d = sof_pend_q;
    stg_e_d    = stg_e_q;
    stg_o_d    = stg_o_q;
    if (accept) begin
      if (in_sof) begin
        g_d        = GW'(1);
        odd_d      = 1'b0;
        width_d    = slice_width;
        stg_vld_d  = 1'b0;
        sof_pend_d = 1'b1;
      end else begin
        if (last_grp) begin
          g_d   = '0;
          odd_d = ~odd_q;
        end else begin
          g_d = g_q + GW'(1);
        end
        if (odd_q && !g_q[0]) begin
          stg_e_d   = rd_data;
          stg_o_d   = in_data_p;
          stg_vld_d = 1'b1;
        end
        if (complete) begin
          stg_vld_d  = 1'b0;
          sof_pend_d = 1'b0;
        end
      end
    end
  end

  always_comb begin
    blk_valid_d = blk_valid_q;
    blk_sof_d   = blk_sof_q;
    blk_p_d     = blk_p_q;
    if (complete) begin
      blk_valid_d = 1'b1;
      blk_sof_d   = sof_pend_q;
      blk_p_d     = g_q[0] ? pack_block(stg_e_q, rd_data, stg_o_q, in_data_p)
                           : pack_block(rd_data, rep_last(rd_data), in_data_p,
                                        rep_last(in_data_p));
    end else if (blk_ready) begin
      blk_valid_d = 1'b0;
      blk_sof_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q         <= '0;
      odd_q       <= 1'b0;
      width_q     <= SwW'(MAX_SLICE_WIDTH);
      stg_vld_q   <= 1'b0;
      sof_pend_q  <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_sof_q   <= 1'b0;
    end else begin
      g_q         <= g_d;
      odd_q       <= odd_d;
      width_q     <= width_d;
      stg_vld_q   <= stg_vld_d;
      sof_pend_q  <= sof_pend_d;
      blk_valid_q <= blk_valid_d;
      blk_sof_q   <= blk_sof_d;
    end
  end

  always_ff @(posedge clk) begin
    stg_e_q <= stg_e_d;
    stg_o_q <= stg_o_d;
    blk_p_q <= blk_p_d;
  end

  assign blk_valid = blk_valid_q;
  assign blk_sof   = blk_sof_q;
  assign blk_p     = blk_p_q;

endmodule

// File: tb/tb_input_block_former.sv
// Bench for input_block_former: directed ramp tables, corner sequences and a random slice vs model.
module tb_input_block_former;
  import input_block_former_pkg::*;

  localparam int unsigned MaxW = 2560;
  localparam int unsigned SwW  = $clog2(MaxW);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [SwW-1:0]  slice_width;
  logic            in_valid, in_ready, in_sof;
  logic [GrpW-1:0] in_data_p;
  logic            blk_valid, blk_ready, blk_sof;
  logic [BlkW-1:0] blk_p;

  always #5 clk = ~clk;

  input_block_former #(.MAX_SLICE_WIDTH(MaxW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .slice_width (slice_width),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sof      (in_sof),
    .in_data_p   (in_data_p),
    .blk_valid   (blk_valid),
    .blk_ready   (blk_ready),
    .blk_sof     (blk_sof),
    .blk_p       (blk_p)
  );

  typedef struct {
    int unsigned width;
    int unsigned blk;
    int unsigned row;
    int unsigned col;
    int unsigned exp_c0;
    bit          exp_sof;
  } vec_t;
  vec_t vecs[12];

  int n_tests = 0;
  int n_fail  = 0;

  logic [BlkW-1:0] exp_q[$];
  bit              exp_sof_q[$];
  logic [BlkW-1:0] cap_p[$];
  bit              cap_sof[$];

  // Reference model: two full pixel rows per component, blocks cut by column arithmetic.
  logic [PixW-1:0] even_px [MaxW][NumComp];
  logic [PixW-1:0] odd_px  [MaxW][NumComp];
  int m_col, m_w;
  bit m_odd, m_pend;

  int              hold_cnt, n_cons;
  bit              rnd_rdy, gaps, seen_stall, prev_hold, last_acc;
  logic [BlkW-1:0] prev_p;

  task automatic check(input string name, input logic [BlkW-1:0] act, input logic [BlkW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_w = 0; m_odd = 0; m_pend = 0;
    exp_q.delete();
    exp_sof_q.delete();
  endtask

  task automatic model_accept(input logic sof, input logic [GrpW-1:0] d, output bit done);
    logic [BlkW-1:0] b;
    int src, bi;
    done = 0;
    if (sof) begin
      m_w = int'(slice_width); m_col = 0; m_odd = 0; m_pend = 1;
    end
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 3; c++)
        if (m_odd) odd_px[m_col+p][c] = d[(p*3 + c)*14 +: 14];
        else       even_px[m_col+p][c] = d[(p*3 + c)*14 +: 14];
    if (m_odd && (((m_col + 4) % 8 == 0) || (m_col + 4 == m_w))) begin
      bi = m_col / 8;
      b  = '0;
      for (int cp = 0; cp < 3; cp++)
        for (int row = 0; row < 2; row++)
          for (int col = 0; col < 8; col++) begin
            src = bi*8 + col;
            if (src >= m_w) src = m_w - 1;
            b[(cp*16 + row*8 + col)*14 +: 14] = (row == 1) ? odd_px[src][cp] : even_px[src][cp];
          end
      exp_q.push_back(b);
      exp_sof_q.push_back(m_pend);
      m_pend = 0;
      done   = 1;
    end
    m_col += 4;
    if (m_col >= m_w) begin
      m_col = 0;
      m_odd = !m_odd;
    end
  endtask

  // One clock: choose blk_ready, observe the handshake before the edge, then check after it.
  task automatic cycle();
    bit acc, cons, done;
    done = 0;
    if (hold_cnt > 0) begin
      blk_ready = 1'b0;
      hold_cnt--;
    end else begin
      blk_ready = rnd_rdy ? ($urandom_range(0, 9) < 7) : 1'b1;
    end
    #1;
    acc  = in_valid & in_ready;
    cons = blk_valid & blk_ready;
    if (in_valid & ~in_ready) seen_stall = 1;
    if (cons) begin
      n_cons++;
      cap_p.push_back(blk_p);
      cap_sof.push_back(blk_sof);
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL extra_block: got unexpected block, want none");
      end else begin
        check("blk_p", blk_p, exp_q.pop_front());
        check("blk_sof", BlkW'(blk_sof), BlkW'(exp_sof_q.pop_front()));
      end
    end
    prev_hold = blk_valid & ~blk_ready;
    prev_p    = blk_p;
    if (acc) model_accept(in_sof, in_data_p, done);
    last_acc = acc;
    @(negedge clk);
    if (prev_hold) begin
      check("hold_valid", BlkW'(blk_valid), BlkW'(1));
      check("hold_p", blk_p, prev_p);
    end
    if (done) check("latency_valid", BlkW'(blk_valid), BlkW'(1));
  endtask

  task automatic send_group(input logic sof, input logic [GrpW-1:0] d);
    int tries;
    if (gaps) while ($urandom_range(0, 3) == 0) cycle();
    in_valid = 1'b1; in_sof = sof; in_data_p = d;
    tries = 0;
    do begin
      cycle();
      tries++;
    end while (!last_acc && tries < 200);
    if (!last_acc) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: got no accept, want accept within 200 cycles");
    end
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  function automatic logic [GrpW-1:0] ramp(input int col0, input int row, input int off);
    logic [GrpW-1:0] d;
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 3; c++)
        d[(p*3 + c)*14 +: 14] = 14'(off + col0 + p + 16*row + 1000*c);
    return d;
  endfunction

  function automatic logic [GrpW-1:0] rand_grp();
    logic [GrpW-1:0] d;
    for (int k = 0; k < 12; k++) d[k*14 +: 14] = 14'($urandom);
    return d;
  endfunction

  task automatic send_slice(input int w, input int rows, input int off, input bit rnd);
    slice_width = SwW'(w);
    for (int r = 0; r < rows; r++)
      for (int gi = 0; gi < w/4; gi++)
        send_group((r == 0) && (gi == 0), rnd ? rand_grp() : ramp(gi*4, r, off));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 100) begin
      cycle();
      t++;
    end
    check("drain_empty", BlkW'(exp_q.size()), BlkW'(0));
    check("no_extra_valid", BlkW'(blk_valid), BlkW'(0));
  endtask

  task automatic apply_table(input int unsigned w);
    logic [BlkW-1:0] bp;
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].width == w) begin
        if (vecs[i].blk >= cap_p.size()) begin
          n_tests++; n_fail++;
          $display("FAIL table_%0d: got %0d blocks, want block %0d", i, cap_p.size(), vecs[i].blk);
        end else begin
          bp = cap_p[vecs[i].blk];
          check($sformatf("table_%0d_c0", i), BlkW'(bp[(vecs[i].row*8 + vecs[i].col)*14 +: 14]),
                BlkW'(vecs[i].exp_c0));
          check($sformatf("table_%0d_sof", i), BlkW'(cap_sof[vecs[i].blk]), BlkW'(vecs[i].exp_sof));
        end
      end
    end
  endtask

  task automatic new_phase();
    cap_p.delete();
    cap_sof.delete();
    n_cons = 0;
  endtask

  initial begin
    logic [BlkW-1:0] bp;
    vecs[0]  = '{16, 0, 0, 0, 0, 1};
    vecs[1]  = '{16, 0, 0, 7, 7, 1};
    vecs[2]  = '{16, 0, 1, 0, 16, 1};
    vecs[3]  = '{16, 0, 1, 7, 23, 1};
    vecs[4]  = '{16, 1, 0, 0, 8, 0};
    vecs[5]  = '{16, 1, 1, 7, 31, 0};
    vecs[6]  = '{12, 1, 0, 0, 8, 0};
    vecs[7]  = '{12, 1, 0, 3, 11, 0};
    vecs[8]  = '{12, 1, 0, 4, 11, 0};
    vecs[9]  = '{12, 1, 0, 7, 11, 0};
    vecs[10] = '{12, 1, 1, 4, 27, 0};
    vecs[11] = '{12, 0, 1, 3, 19, 1};

    in_valid = 0; in_sof = 0; in_data_p = '0; blk_ready = 1; slice_width = SwW'(16);
    hold_cnt = 0; rnd_rdy = 0; gaps = 0; seen_stall = 0; prev_hold = 0; last_acc = 0;
    prev_p = '0;
    model_reset();
    new_phase();

    repeat (3) @(negedge clk);
    check("rst_blk_valid", BlkW'(blk_valid), BlkW'(0));
    check("rst_blk_sof", BlkW'(blk_sof), BlkW'(0));
    check("rst_in_ready", BlkW'(in_ready), BlkW'(1));
    rst_n = 1'b1;
    @(negedge clk);

    // Width 16 ramp: two full blocks.
    new_phase();
    send_slice(16, 2, 0, 0);
    drain();
    check("w16_count", BlkW'(n_cons), BlkW'(2));
    apply_table(16);

    // Width 12 ramp: second block padded from column 11.
    new_phase();
    send_slice(12, 2, 0, 0);
    drain();
    check("w12_count", BlkW'(n_cons), BlkW'(2));
    apply_table(12);

    // Output back-pressure for 10 cycles during an odd row.
    new_phase();
    seen_stall = 0;
    slice_width = SwW'(16);
    for (int r = 0; r < 4; r++)
      for (int gi = 0; gi < 4; gi++) begin
        if (r == 1 && gi == 0) hold_cnt = 10;
        send_group((r == 0) && (gi == 0), ramp(gi*4, r, 50));
      end
    drain();
    check("bp_stall_seen", BlkW'(seen_stall), BlkW'(1));
    check("bp_count", BlkW'(n_cons), BlkW'(4));

    // in_sof arriving at even-row g=2 restarts the slice.
    new_phase();
    slice_width = SwW'(16);
    send_group(1'b1, ramp(0, 0, 0));
    send_group(1'b0, ramp(4, 0, 0));
    send_slice(16, 2, 100, 0);
    drain();
    check("sof_count", BlkW'(n_cons), BlkW'(2));
    if (cap_p.size() > 0) begin
      bp = cap_p[0];
      check("sof_blk0_c0", BlkW'(bp[13:0]), BlkW'(100));
      check("sof_blk0_flag", BlkW'(cap_sof[0]), BlkW'(1));
    end else begin
      n_tests++; n_fail++;
      $display("FAIL sof_blk0: got 0 blocks, want 2");
    end

    // Reset pulsed while a completed block waits in an odd row.
    new_phase();
    slice_width = SwW'(16);
    for (int gi = 0; gi < 4; gi++) send_group(gi == 0, ramp(gi*4, 0, 0));
    hold_cnt = 30;
    send_group(1'b0, ramp(0, 1, 0));
    send_group(1'b0, ramp(4, 1, 0));
    check("pre_rst_valid", BlkW'(blk_valid), BlkW'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", BlkW'(blk_valid), BlkW'(0));
    check("mid_rst_sof", BlkW'(blk_sof), BlkW'(0));
    model_reset();
    prev_hold = 0;
    hold_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    new_phase();
    send_slice(16, 2, 200, 0);
    drain();
    check("post_rst_count", BlkW'(n_cons), BlkW'(2));

    // Full-width random slice with input gaps and output throttling.
    new_phase();
    gaps = 1; rnd_rdy = 1;
    send_slice(2560, 4, 0, 1);
    drain();
    check("rand_count", BlkW'(n_cons), BlkW'(640));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish, want finish before 3000000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/input_block_former.md
INPUT_BLOCK_FORMER -- requirements
Module: input_block_former

Interface
REQ-001 Parameter MAX_SLICE_WIDTH, default 2560, maximum slice width in pixels.
REQ-002 clk  input  1  clock; all state rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 slice_width  input  $clog2(MAX_SLICE_WIDTH)  pixels per row; multiple of 4, range 8..MAX_SLICE_WIDTH; sampled on accepted in_sof.
REQ-005 in_valid  input  1  raster group valid.
REQ-006 in_ready  output  1  group accepted when in_valid & in_ready.
REQ-007 in_sof  input  1  qualifies first group of a slice.
REQ-008 in_data_p  input  4*3*14  4 pixels {p3c2,p3c1,p3c0,...,p0c2,p0c1,p0c0}; p0 leftmost.
REQ-009 blk_valid  output  1  2x8 block valid.
REQ-010 blk_ready  input  1  block consumed when blk_valid & blk_ready.
REQ-011 blk_sof  output  1  qualifies first block of a slice.
REQ-012 blk_p  output  2*8*3*14  block; pixel (cp,row,col) at bits [(cp*16+row*8+col)*14 +: 14]; row 0 = even row.

Function
REQ-013 Accepted groups SHALL be counted by column-group index g (0..slice_width/4-1) and row parity bit; g wraps to 0 and parity toggles after the last group of a row.
REQ-014 Even-row groups SHALL be written to the line buffer at address g; in_ready SHALL be 1 during even rows.
REQ-015 Odd-row group g SHALL be combined with even-row groups read from address g; even g held in a staging register with its even partner.
REQ-016 Accepting odd group with odd g SHALL complete block g>>1: cols 0-3 from group g-1, cols 4-7 from group g, both rows.
REQ-017 When slice_width/4 is odd, accepting the last odd-row group SHALL complete a final block whose cols 4-7 replicate col 3 of each row and component.
REQ-018 Block latency: blk_valid SHALL assert the cycle after the completing group is accepted.
REQ-019 blk_valid/blk_p/blk_sof SHALL hold stable until blk_ready; one output register, no further queuing.
REQ-020 in_ready SHALL be 0 only in an odd row when the next group would complete a block while blk_valid & ~blk_ready.
REQ-021 Simultaneous block consumption and completion SHALL load the new block with no bubble (full throughput: one block per two odd-row groups).
REQ-022 Accepted in_sof SHALL reset g and parity to 0 and discard any staged half block, that group being even-row g=0.
REQ-023 blk_sof SHALL be 1 on the first block completed after an accepted in_sof, 0 otherwise.
REQ-024 Line-buffer read SHALL be issued ahead so no odd-row stall arises from read latency.
REQ-025 Chroma subsampling is out of scope; all three components carry 8 columns.

Reset
REQ-026 On rst_n low: blk_valid=0, blk_sof=0, g=0, parity=even, staging empty; blk_p and RAM contents undefined.
REQ-027 Reset mid-slice SHALL drop all partial data; first post-reset group is treated as even row g=0.

Structure
REQ-028 Pixel width 14, components 3, group size 4, block 2x8 SHALL be constants in the shared decoder/encoder package.
REQ-029 Line buffer SHALL be one dp_ram instance, depth MAX_SLICE_WIDTH/4, width 3*4*14, one-cycle read latency.

Verification
REQ-030 width 16, rows ramp (c0=col+16*row): 8 groups -> 2 blocks; block 0 row0 c0=0..7, row1 c0=16..23; blk_sof on block 0 only.
REQ-031 width 12: 6 groups -> 2 blocks; block 1 row0 c0=8,9,10,11,11,11,11,11.
REQ-032 blk_ready held 0 for 10 cycles during odd row, in_valid constant 1 -> in_ready drops, no block lost or duplicated, blk_p stable.
REQ-033 in_sof at even-row g=2 of width 16 -> counters reset; next block built from new data with blk_sof=1.
REQ-034 rst_n pulsed mid odd row -> blk_valid=0 immediately; subsequent clean slice produces correct blocks.
REQ-035 Random in_valid gaps and blk_ready throttling, width 2560, 4 rows -> 640 blocks matching reference model.
